seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Parametrised, time-multiplexed multi-digit 7-segment display controller with an Avalon-MM slave register port. It holds a packed hex value for up to 8 digits and scans one digit at a time onto a shared segment bus with a one-hot digit select. It sits in the `avalon_displays7seg` Qsys component, between the interconnect and the board display pins.

## Interface

Parameters:
- `NUM_DIGITS`, 4: number of digits, legal range 1..8.
- `SCAN_DIV`, 50000: clock cycles each digit stays lit, minimum 2.
- `INVERT`, 0: when 1, `seg_out` and `dig_sel` are active-low (bitwise inverted at the output).

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `avs_address` in 2: register select.
- `avs_write` in 1: write strobe.
- `avs_writedata` in 32: write data.
- `avs_read` in 1: read strobe.
- `avs_readdata` out 32: read data, fixed 1-cycle read latency.
- `seg_out` out 8: segments, bits 6:0 = g..a, bit 7 = dp.
- `dig_sel` out `NUM_DIGITS`: one-hot digit enable; bit 0 is the rightmost digit.

## Operation

Registers (all reset to 0; unused bits read 0):
- 0 VALUE: bits `4*NUM_DIGITS-1:0`, nibble i = digit i.
- 1 CTRL: bit0 EN (scan enable), bit1 LZS (leading-zero suppress).
- 2 BLANK: bit i forces digit i dark.
- 3 DP: bit i lights the dp of digit i.

Register access:
- Writes update the register on the clock edge where `avs_write`=1.
- A read loads `avs_readdata` on the edge where `avs_read`=1. The value is valid the following cycle.
- Read and write to the same address in the same cycle: the read returns the old value.

Scan:
- Prescaler counts 0..`SCAN_DIV`-1.
- At the terminal count, the digit index advances by one, wrapping from `NUM_DIGITS`-1 to 0.
- With `NUM_DIGITS`=1 the index stays at 0.

Digit i is dark (segments 0, dp 0) when any of these holds:
- BLANK[i] = 1.
- LZS = 1, i > 0, and nibbles i..`NUM_DIGITS`-1 are all zero. Digit 0 is never suppressed.

Otherwise:
- Bits 6:0 carry the hex glyph of nibble i, with standard a..g patterns 0x3F, 0x06, … 0x71.
- Bit 7 carries DP[i].

EN = 0:
- Prescaler and index are held at 0.
- `dig_sel` is all inactive and `seg_out` is all inactive.

## Timing

- `seg_out` and `dig_sel` are registered.
- They reflect the index and register contents from the previous edge. A write at edge t is visible on the pins after edge t+1.
- Each digit is lit for exactly `SCAN_DIV` cycles. A full frame takes `NUM_DIGITS`×`SCAN_DIV` cycles.
- `dig_sel` and `seg_out` always change on the same edge, so there is no ghosting cycle with a mismatched digit and pattern.
- EN 0→1:
  - Scanning starts at digit 0.
  - First lit output appears 1 cycle after the write edge.
  - Index first advances `SCAN_DIV` cycles after that edge.
- EN 1→0: outputs go inactive 1 cycle after the write edge. Index and prescaler clear at the write edge.
- Asserting `reset` at any time immediately forces:
  - all registers to 0;
  - index and prescaler to 0;
  - `avs_readdata` to 0;
  - `seg_out` to the inactive pattern (0x00, or 0xFF if `INVERT`);
  - `dig_sel` to inactive (all 0, or all 1 if `INVERT`).
- No state survives reset.

## Configuration

- `SEG7_DP_EN` defined: DP register is implemented, and `seg_out[7]` follows the rules above.
- `SEG7_DP_EN` undefined:
  - Address 3 writes are ignored and reads return 0.
  - `seg_out[7]` is held inactive (0, or 1 if `INVERT`).

## Structure

- Shared package `seg7_pkg` holds:
  - the 16-entry glyph constant array;
  - register address localparams (`REG_VALUE`, `REG_CTRL`, `REG_BLANK`, `REG_DP`);
  - CTRL bit-index constants.
- One sub-module, `seg7_glyph`: a combinational nibble-to-7-bit decoder, instantiated once on the muxed nibble. Polarity inversion is applied only at the top-level output registers, not inside the decoder.

## Test plan

Bench settings: `NUM_DIGITS`=4, `SCAN_DIV`=4, `INVERT`=0 unless noted.

1. Reset mid-scan, with EN=1 and index=2: outputs go to 0 immediately, even without a clock edge; all registers read 0 afterwards.
2. Write VALUE=0x1234, CTRL=1: `dig_sel` steps 0001→0010→0100→1000→0001, 4 cycles each; `seg_out` is 0x66, 0x4F, 0x5B, 0x06 respectively.
3. VALUE=0x0050, CTRL=3 (LZS on): digits 3 and 2 show seg 0x00; digit 1 shows 0x6D; digit 0 shows 0x3F.
4. BLANK=0x2, DP=0x1, VALUE=0xABCD: digit 1 is dark; digit 0 shows 0xDE (0x5E | dp). Rebuild without `SEG7_DP_EN`: digit 0 shows 0x5E, and reading address 3 returns 0.
5. Read/write same cycle: write VALUE=0xFFFF while reading address 0 when VALUE was 0x1234 → `avs_readdata`=0x1234. Next read → 0xFFFF.
6. `INVERT`=1, `NUM_DIGITS`=1, VALUE=0x8, EN=1: `dig_sel`=0 constantly, `seg_out`=0x80. Then EN=0: `dig_sel`=1, `seg_out`=0xFF after 1 cycle.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: glyph table, register map, CTRL bits.
package seg7_pkg;

   // Register addresses on the Avalon-MM slave port
   localparam logic [1:0] REG_VALUE = 2'd0;
   localparam logic [1:0] REG_CTRL  = 2'd1;
   localparam logic [1:0] REG_BLANK = 2'd2;
   localparam logic [1:0] REG_DP    = 2'd3;

   // CTRL register bit positions
   localparam int CTRL_EN  = 0;
   localparam int CTRL_LZS = 1;

   typedef struct packed {
      logic lzs;
      logic en;
   } ctrl_t;

   // Hex glyphs, bit order g..a (bit 6 = g, bit 0 = a), active-high
   localparam logic [6:0] GLYPH [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

endpackage

// File: rtl/seg7_glyph.sv
// Combinational nibble-to-segment decoder, always active-high.
module seg7_glyph
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = GLYPH[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed multi-digit 7-segment controller with an Avalon-MM register port.
// Optional feature: define SEG7_DP_EN to implement the DP register (address 3).
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 50000,
   parameter int INVERT     = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            avs_address,
   input  logic                  avs_write,
   input  logic [31:0]           avs_writedata,
   input  logic                  avs_read,
   output logic [31:0]           avs_readdata,
   output logic [7:0]            seg_out,
   output logic [NUM_DIGITS-1:0] dig_sel
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int PRE_W = $clog2(SCAN_DIV);
   localparam int VAL_W = 4 * NUM_DIGITS;

   // Inactive pin levels; XOR-ing with these applies the output polarity
   localparam logic [7:0]            SEG_OFF = {8{INVERT != 0}};
   localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{INVERT != 0}};

   logic [VAL_W-1:0]      value_q;
   ctrl_t                 ctrl_q;
   logic [NUM_DIGITS-1:0] blank_q;
   logic [NUM_DIGITS-1:0] dp_q;

   logic [PRE_W-1:0]      pre_q;
   logic [IDX_W-1:0]      idx_q;

   logic                  en_next;
   logic [31:0]           rd_mux;
   logic [3:0]            nibble;
   logic [6:0]            glyph;
   logic                  blank_bit;
   logic                  dp_bit;
   logic                  lz_bit;
   logic                  dark;
   logic [NUM_DIGITS-1:0] lz_vec;
   logic [NUM_DIGITS-1:0] onehot;

   // Upper data bits beyond the implemented registers are intentionally ignored
   logic unused_wdata;
   assign unused_wdata = ^avs_writedata;

   // EN as it will be after this edge; lets a disabling write clear the scan at the same edge
   assign en_next = (avs_write && avs_address == REG_CTRL) ? avs_writedata[CTRL_EN] : ctrl_q.en;

   // Register file writes (VALUE, CTRL, BLANK)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value_q <= '0;
         ctrl_q  <= '0;
         blank_q <= '0;
      end else if (avs_write) begin
         case (avs_address)
            REG_VALUE: value_q <= avs_writedata[VAL_W-1:0];
            REG_CTRL:  ctrl_q  <= ctrl_t'(avs_writedata[1:0]);
            REG_BLANK: blank_q <= avs_writedata[NUM_DIGITS-1:0];
            default: ;
         endcase
      end
   end

`ifdef SEG7_DP_EN
   // DP register write
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         dp_q <= '0;
      else if (avs_write && avs_address == REG_DP)
         dp_q <= avs_writedata[NUM_DIGITS-1:0];
   end
`else
   assign dp_q = '0;
`endif

   // Read mux; unimplemented bits read as zero
   always_comb begin
      rd_mux = '0;
      case (avs_address)
         REG_VALUE: rd_mux[VAL_W-1:0]      = value_q;
         REG_CTRL:  rd_mux[1:0]            = ctrl_q;
         REG_BLANK: rd_mux[NUM_DIGITS-1:0] = blank_q;
         default:   rd_mux[NUM_DIGITS-1:0] = dp_q;
      endcase
   end

   // Read data register, loaded only on a read strobe (returns pre-write value on collision)
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         avs_readdata <= '0;
      else if (avs_read)
         avs_readdata <= rd_mux;
   end

   // Prescaler and digit index; held at 0 while disabled, first count on the edge after enable
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_q <= '0;
         idx_q <= '0;
      end else if (!en_next) begin
         pre_q <= '0;
         idx_q <= '0;
      end else if (ctrl_q.en) begin
         if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
            pre_q <= '0;
            idx_q <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
         end else begin
            pre_q <= pre_q + PRE_W'(1);
         end
      end
   end

   // Per-digit leading-zero flag: digit i and everything above it is zero (never digit 0)
   always_comb begin
      lz_vec = '0;
      for (int i = 1; i < NUM_DIGITS; i++)
         lz_vec[i] = ((value_q >> (4 * i)) == '0);
   end

   // Select the current digit's nibble and attributes
   always_comb begin
      nibble    = '0;
      blank_bit = 1'b0;
      dp_bit    = 1'b0;
      lz_bit    = 1'b0;
      onehot    = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            nibble    = value_q[4*i +: 4];
            blank_bit = blank_q[i];
            dp_bit    = dp_q[i];
            lz_bit    = lz_vec[i];
            onehot[i] = 1'b1;
         end
      end
   end

   seg7_glyph u_glyph (
      .nibble (nibble),
      .seg    (glyph)
   );

   assign dark = blank_bit | (ctrl_q.lzs & lz_bit);

   // Output registers: digit select and pattern update together so no ghost cycle exists
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg_out <= SEG_OFF;
         dig_sel <= DIG_OFF;
      end else if (!ctrl_q.en) begin
         seg_out <= SEG_OFF;
         dig_sel <= DIG_OFF;
      end else begin
         seg_out <= (dark ? 8'h00 : {dp_bit, glyph}) ^ SEG_OFF;
         dig_sel <= onehot ^ DIG_OFF;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed scenarios plus random register traffic
// compared against a cycle-count based reference model.
module tb_seg7_scan_driver;

   localparam int ND = 4;
   localparam int SD = 4;
`ifdef SEG7_DP_EN
   localparam bit DP_EN = 1'b1;
`else
   localparam bit DP_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  avs_address = '0;
   logic        avs_write = 1'b0;
   logic [31:0] avs_writedata = '0;
   logic        avs_read = 1'b0;
   logic [31:0] avs_readdata;
   logic [7:0]  seg_out;
   logic [ND-1:0] dig_sel;

   logic [1:0]  b_address = '0;
   logic        b_write = 1'b0;
   logic [31:0] b_writedata = '0;
   logic        b_read = 1'b0;
   logic [31:0] b_readdata;
   logic [7:0]  b_seg;
   logic [0:0]  b_dig;

   always #5 clk = ~clk;

   seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .INVERT(0)) u_dut (
      .clk(clk), .reset(reset), .avs_address(avs_address), .avs_write(avs_write),
      .avs_writedata(avs_writedata), .avs_read(avs_read), .avs_readdata(avs_readdata),
      .seg_out(seg_out), .dig_sel(dig_sel)
   );

   seg7_scan_driver #(.NUM_DIGITS(1), .SCAN_DIV(2), .INVERT(1)) u_dut_inv (
      .clk(clk), .reset(reset), .avs_address(b_address), .avs_write(b_write),
      .avs_writedata(b_writedata), .avs_read(b_read), .avs_readdata(b_readdata),
      .seg_out(b_seg), .dig_sel(b_dig)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [6:0] gl [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   longint unsigned m_val = 0;
   logic [1:0]    m_ctrl = '0;
   logic [ND-1:0] m_blank = '0;
   logic [ND-1:0] m_dp = '0;
   int            m_lit = 0;     // cycles elapsed since scanning was enabled
   logic [7:0]    exp_seg = '0;
   logic [ND-1:0] exp_dig = '0;
   logic [31:0]   exp_rd = '0;
   bit            chk_on = 1'b0;

   function automatic logic [31:0] m_read(input logic [1:0] a);
      case (a)
         2'd0: return 32'(m_val);
         2'd1: return {30'b0, m_ctrl};
         2'd2: return 32'(m_blank);
         default: return DP_EN ? 32'(m_dp) : 32'h0;
      endcase
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_val = 0; m_ctrl = '0; m_blank = '0; m_dp = '0; m_lit = 0;
         exp_seg = '0; exp_dig = '0; exp_rd = '0;
      end else begin
         bit old_en;
         int d;
         int nib;
         bit dark;
         old_en = m_ctrl[0];
         if (m_ctrl[0]) begin
            d = (m_lit / SD) % ND;
            nib = int'((m_val >> (4 * d)) & 15);
            dark = m_blank[d] || (m_ctrl[1] && d > 0 && (m_val >> (4 * d)) == 0);
            exp_dig = ND'(1) << d;
            exp_seg = dark ? 8'h00 : {DP_EN && m_dp[d], gl[nib]};
         end else begin
            exp_dig = '0;
            exp_seg = '0;
         end
         if (avs_read) exp_rd = m_read(avs_address);
         if (avs_write) begin
            case (avs_address)
               2'd0: m_val = avs_writedata & ((64'd1 << (4 * ND)) - 1);
               2'd1: m_ctrl = avs_writedata[1:0];
               2'd2: m_blank = avs_writedata[ND-1:0];
               default: if (DP_EN) m_dp = avs_writedata[ND-1:0];
            endcase
         end
         if (m_ctrl[0] && old_en) m_lit++;
         else m_lit = 0;
      end
   end

   // continuous comparison of pins and read data against the model
   always @(posedge clk) begin
      #1;
      if (chk_on && !reset) begin
         chk("dig_sel", 32'(dig_sel), 32'(exp_dig));
         chk("seg_out", 32'(seg_out), 32'(exp_seg));
         chk("readdata", avs_readdata, exp_rd);
      end
   end

   // ---------------- bus tasks ----------------
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      avs_address = a; avs_writedata = d; avs_write = 1'b1;
      @(negedge clk);
      avs_write = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
      @(negedge clk);
      avs_address = a; avs_read = 1'b1;
      @(negedge clk);
      avs_read = 1'b0;
      chk(tag, avs_readdata, exp);
   endtask

   task automatic rd_raw(input logic [1:0] a);
      @(negedge clk);
      avs_address = a; avs_read = 1'b1;
      @(negedge clk);
      avs_read = 1'b0;
   endtask

   task automatic wr_b(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      b_address = a; b_writedata = d; b_write = 1'b1;
      @(negedge clk);
      b_write = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] v;
      int op;
      #1 reset = 1'b1;
      #2;
      chk("rst_dig", 32'(dig_sel), 32'h0);
      chk("rst_seg", 32'(seg_out), 32'h0);
      chk("rst_rd", avs_readdata, 32'h0);
      chk("rst_inv_dig", 32'(b_dig), 32'h1);
      chk("rst_inv_seg", 32'(b_seg), 32'hFF);
      @(negedge clk);
      reset = 1'b0;
      chk_on = 1'b1;
      for (int a = 0; a < 4; a++) rd(2'(a), 32'h0, "rst_reg");

      // basic scan of 0x1234
      wr(2'd0, 32'h1234);
      wr(2'd1, 32'h1);
      @(negedge clk);
      chk("scan_d0_sel", 32'(dig_sel), 32'h1); chk("scan_d0_seg", 32'(seg_out), 32'h66);
      repeat (SD) @(negedge clk);
      chk("scan_d1_sel", 32'(dig_sel), 32'h2); chk("scan_d1_seg", 32'(seg_out), 32'h4F);
      repeat (SD) @(negedge clk);
      chk("scan_d2_sel", 32'(dig_sel), 32'h4); chk("scan_d2_seg", 32'(seg_out), 32'h5B);
      repeat (SD) @(negedge clk);
      chk("scan_d3_sel", 32'(dig_sel), 32'h8); chk("scan_d3_seg", 32'(seg_out), 32'h06);
      repeat (SD) @(negedge clk);
      chk("scan_wrap_sel", 32'(dig_sel), 32'h1); chk("scan_wrap_seg", 32'(seg_out), 32'h66);

      // leading-zero suppression
      wr(2'd0, 32'h0050);
      wr(2'd1, 32'h3);
      repeat (2 * ND * SD) @(negedge clk);

      // blank and decimal point
      wr(2'd1, 32'h1);
      wr(2'd2, 32'h2);
      wr(2'd3, 32'h1);
      wr(2'd0, 32'hABCD);
      repeat (2 * ND * SD) @(negedge clk);
      rd(2'd3, DP_EN ? 32'h1 : 32'h0, "rd_dp");
      rd(2'd2, 32'h2, "rd_blank");
      wr(2'd2, 32'h0);

      // same-cycle read and write returns the old value
      wr(2'd0, 32'h1234);
      @(negedge clk);
      avs_address = 2'd0; avs_writedata = 32'hFFFF; avs_write = 1'b1; avs_read = 1'b1;
      @(negedge clk);
      avs_write = 1'b0; avs_read = 1'b0;
      chk("rw_old", avs_readdata, 32'h1234);
      rd(2'd0, 32'hFFFF, "rw_new");

      // asynchronous reset mid-scan with index 2
      wr(2'd1, 32'h0);
      wr(2'd1, 32'h1);
      repeat (2 * SD + 1) @(negedge clk);
      chk("pre_rst_sel", 32'(dig_sel), 32'h4);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_sel", 32'(dig_sel), 32'h0);
      chk("async_rst_seg", 32'(seg_out), 32'h0);
      chk("async_rst_rd", avs_readdata, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      for (int a = 0; a < 4; a++) rd(2'(a), 32'h0, "post_rst_reg");

      // random register traffic against the model
      for (int it = 0; it < 250; it++) begin
         op = int'($urandom_range(0, 9));
         if (op < 6) begin
            case ($urandom_range(0, 3))
               0: begin v = $urandom >> $urandom_range(0, 31); wr(2'd0, v); end
               1: begin v = $urandom_range(0, 3); if ($urandom_range(0, 3) != 0) v[0] = 1'b1; wr(2'd1, v); end
               2: begin v = ($urandom_range(0, 2) == 0) ? $urandom : 32'h0; wr(2'd2, v); end
               default: begin v = $urandom; wr(2'd3, v); end
            endcase
         end else if (op < 8) begin
            rd_raw(2'($urandom_range(0, 3)));
         end else begin
            repeat ($urandom_range(1, 12)) @(negedge clk);
         end
      end

      // single-digit, inverted-polarity instance
      wr_b(2'd0, 32'h8);
      wr_b(2'd1, 32'h1);
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         chk("inv_on_dig", 32'(b_dig), 32'h0);
         chk("inv_on_seg", 32'(b_seg), 32'h80);
         @(negedge clk);
      end
      wr_b(2'd1, 32'h0);
      @(negedge clk);
      chk("inv_off_dig", 32'(b_dig), 32'h1);
      chk("inv_off_seg", 32'(b_seg), 32'hFF);

      chk_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
